// File: rtl/branch_target_pipe.sv
// Pipelined branch-target unit: target = pc4 + (imm << SHIFT), taken decode,
// LATENCY register stages with flush/stall, and a saturating taken-branch counter.
module branch_target_pipe #(
  parameter int unsigned NBITS       = 32,
  parameter int unsigned SHIFT       = 2,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic [NBITS-1:0] i_pc4,
  input  logic [NBITS-1:0] i_ext_imm,
  input  logic [1:0]       i_branch_type,
  input  logic             i_alu_zero,
  output logic             o_valid,
  output logic [NBITS-1:0] o_target,
  output logic             o_taken,
  output logic             o_pc_src,
  output logic             o_misalign,
  output logic [CNT_W-1:0] o_taken_count
);

  if (LATENCY < 1 || LATENCY > 3) begin : g_latency_check
    $error("branch_target_pipe: LATENCY must be in 1..3");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // pc_src and misalign are derived at the input so every output is a flop
  typedef struct packed {
    logic             valid;
    logic             taken;
    logic             pc_src;
    logic             misalign;
    logic [NBITS-1:0] target;
  } stage_t;

  stage_t           stage_q [LATENCY];
  stage_t           stage_in_c;
  stage_t           out_s;
  logic [NBITS-1:0] target_c;
  logic             taken_c;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    target_c = i_pc4 + NBITS'(i_ext_imm << SHIFT);
    taken_c  = 1'b0;
    case (i_branch_type)
      2'b01:   taken_c = i_alu_zero;
      2'b10:   taken_c = ~i_alu_zero;
      2'b11:   taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
    stage_in_c          = '0;
    stage_in_c.valid    = i_valid;
    stage_in_c.taken    = i_valid & taken_c;
    stage_in_c.pc_src   = i_valid & taken_c;
    stage_in_c.misalign = (ALIGN_CHECK != 0) && i_valid && taken_c && (|target_c[1:0]);
    stage_in_c.target   = target_c;
  end

  // Reset and flush both clear every stage; stall freezes the whole pipe
  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    if (k == 0) begin : g_head
      always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
          stage_q[k] <= '0;
        end else if (!i_stall) begin
          stage_q[k] <= stage_in_c;
        end
      end
    end else begin : g_tail
      always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
          stage_q[k] <= '0;
        end else if (!i_stall) begin
          stage_q[k] <= stage_q[k-1];
        end
      end
    end
  end

  assign out_s = stage_q[LATENCY-1];

  // Each delivered taken entry counts once as it leaves the output stage
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else if (out_s.valid && out_s.taken && !i_stall && !i_flush && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign o_valid       = out_s.valid;
  assign o_target      = out_s.target;
  assign o_taken       = out_s.taken;
  assign o_pc_src      = out_s.pc_src;
  assign o_misalign    = out_s.misalign;
  assign o_taken_count = count_q;

endmodule

// File: tb/tb_branch_target_pipe.sv
// Directed bench for branch_target_pipe: main instance LATENCY=2/CNT_W=3 plus
// SHIFT=0 instances at LATENCY 1, 2 (no align check) and 3 sharing the same inputs.
module tb_branch_target_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid, stall, flush, alu_zero;
  logic [31:0] pc4, imm;
  logic [1:0]  btype;

  logic        v2, tk2, ps2, ma2;
  logic [31:0] tg2;
  logic [2:0]  cnt2;

  logic        va, tka, psa, maa;
  logic [31:0] tga;
  logic [15:0] cnta;
  logic        vb, tkb, psb, mab;
  logic [31:0] tgb;
  logic [15:0] cntb;
  logic        vc, tkc, psc, mac;
  logic [31:0] tgc;
  logic [15:0] cntc;

  int checks = 0;
  int errors = 0;

  branch_target_pipe #(.NBITS(32), .SHIFT(2), .LATENCY(2), .CNT_W(3), .ALIGN_CHECK(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_pc4(pc4), .i_ext_imm(imm), .i_branch_type(btype), .i_alu_zero(alu_zero),
    .o_valid(v2), .o_target(tg2), .o_taken(tk2), .o_pc_src(ps2), .o_misalign(ma2),
    .o_taken_count(cnt2));

  branch_target_pipe #(.NBITS(32), .SHIFT(0), .LATENCY(1), .CNT_W(16), .ALIGN_CHECK(1)) dut_l1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_pc4(pc4), .i_ext_imm(imm), .i_branch_type(btype), .i_alu_zero(alu_zero),
    .o_valid(va), .o_target(tga), .o_taken(tka), .o_pc_src(psa), .o_misalign(maa),
    .o_taken_count(cnta));

  branch_target_pipe #(.NBITS(32), .SHIFT(0), .LATENCY(2), .CNT_W(16), .ALIGN_CHECK(0)) dut_l2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_pc4(pc4), .i_ext_imm(imm), .i_branch_type(btype), .i_alu_zero(alu_zero),
    .o_valid(vb), .o_target(tgb), .o_taken(tkb), .o_pc_src(psb), .o_misalign(mab),
    .o_taken_count(cntb));

  branch_target_pipe #(.NBITS(32), .SHIFT(0), .LATENCY(3), .CNT_W(16), .ALIGN_CHECK(1)) dut_l3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_pc4(pc4), .i_ext_imm(imm), .i_branch_type(btype), .i_alu_zero(alu_zero),
    .o_valid(vc), .o_target(tgc), .o_taken(tkc), .o_pc_src(psc), .o_misalign(mac),
    .o_taken_count(cntc));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] i,
                       input logic [1:0] t, input logic z);
    valid = v; pc4 = p; imm = i; btype = t; alu_zero = z;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] t,
                         input logic tk, input logic ps, input logic ma);
    chk({tag, ".valid"}, 64'(v2), 64'(v));
    chk({tag, ".target"}, 64'(tg2), 64'(t));
    chk({tag, ".taken"}, 64'(tk2), 64'(tk));
    chk({tag, ".pc_src"}, 64'(ps2), 64'(ps));
    chk({tag, ".misalign"}, 64'(ma2), 64'(ma));
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    tick(); tick();
    chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.count", 64'(cnt2), 64'd0);
    rst_n = 1'b1;

    // 1: BEQ taken, 2-cycle latency
    drive(1'b1, 32'h4, 32'h1, 2'b01, 1'b1);
    tick();
    chk("t1.latency", 64'(v2), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    tick();
    chk_out("t1", 1'b1, 32'h8, 1'b1, 1'b1, 1'b0);
    chk("t1.count_pre", 64'(cnt2), 64'd0);
    tick();
    chk("t1.count", 64'(cnt2), 64'd1);
    chk("t1.bubble", 64'(v2), 64'd0);

    // 2: wrap-around target, then BNE not taken with negative offset
    drive(1'b1, 32'hFFFF_FFFC, 32'h1, 2'b11, 1'b0);
    tick();
    drive(1'b1, 32'h100, 32'hFFFF_FFFF, 2'b10, 1'b1);
    tick();
    chk_out("t2a", 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    tick();
    chk_out("t2b", 1'b1, 32'hFC, 1'b0, 1'b0, 1'b0);
    chk("t2.count", 64'(cnt2), 64'd2);
    tick();
    chk("t2.count_nt", 64'(cnt2), 64'd2);

    // 3: back-to-back stream with a 3-cycle stall
    drive(1'b1, 32'h1000, 32'h0, 2'b11, 1'b0);
    tick();
    drive(1'b1, 32'h1010, 32'h1, 2'b11, 1'b0);
    tick();
    chk("t3.e0", 64'(tg2), 64'h1000);
    drive(1'b1, 32'h1020, 32'h2, 2'b11, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3.stall_tgt", 64'(tg2), 64'h1000);
      chk("t3.stall_cnt", 64'(cnt2), 64'd2);
    end
    stall = 1'b0;
    tick();
    chk("t3.e1", 64'(tg2), 64'h1014);
    chk("t3.cnt_e0", 64'(cnt2), 64'd3);
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    tick();
    chk("t3.e2", 64'(tg2), 64'h1028);
    chk("t3.e2v", 64'(v2), 64'd1);
    chk("t3.cnt_e1", 64'(cnt2), 64'd4);
    tick();
    chk("t3.end_v", 64'(v2), 64'd0);
    chk("t3.cnt_e2", 64'(cnt2), 64'd5);

    // 4: flush together with stall while 2 entries in flight
    drive(1'b1, 32'h2000, 32'h0, 2'b11, 1'b0);
    tick();
    drive(1'b1, 32'h3000, 32'h0, 2'b11, 1'b0);
    tick();
    chk("t4.f0", 64'(tg2), 64'h2000);
    drive(1'b1, 32'h4000, 32'h0, 2'b11, 1'b0);
    flush = 1'b1; stall = 1'b1;
    tick();
    chk_out("t4.flushed", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t4.cnt", 64'(cnt2), 64'd5);
    flush = 1'b0; stall = 1'b0;
    drive(1'b1, 32'h5000, 32'h0, 2'b11, 1'b0);
    tick();
    chk("t4.drained", 64'(v2), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    tick();
    chk_out("t4.f3", 1'b1, 32'h5000, 1'b1, 1'b1, 1'b0);
    tick();
    chk("t4.cnt_f3", 64'(cnt2), 64'd6);

    // 5: 9 taken branches saturate a 3-bit counter; reset clears everything
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t5.cnt_clr", 64'(cnt2), 64'd0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 32'h0, 2'b11, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    tick(); tick(); tick();
    chk("t5.sat", 64'(cnt2), 64'd7);
    drive(1'b1, 32'h700, 32'h0, 2'b11, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    chk_out("t5.reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t5.reset_cnt", 64'(cnt2), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    tick();
    chk("t5.discard", 64'(v2), 64'd0);
    tick();
    chk("t5.discard2", 64'(v2), 64'd0);

    // 6: SHIFT=0 misaligned target across latencies
    drive(1'b1, 32'h4, 32'h2, 2'b11, 1'b0);
    tick();
    chk("t6.l1.target", 64'(tga), 64'h6);
    chk("t6.l1.misalign", 64'(maa), 64'd1);
    chk("t6.l1.pc_src", 64'(psa), 64'd1);
    chk("t6.l1.taken", 64'(tka), 64'd1);
    chk("t6.l2.early", 64'(vb), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    tick();
    chk("t6.l2.target", 64'(tgb), 64'h6);
    chk("t6.l2.valid", 64'(vb), 64'd1);
    chk("t6.l2.no_align", 64'(mab), 64'd0);
    chk_out("t6.main", 1'b1, 32'hC, 1'b1, 1'b1, 1'b0);
    chk("t6.l3.early", 64'(vc), 64'd0);
    tick();
    chk("t6.l3.target", 64'(tgc), 64'h6);
    chk("t6.l3.misalign", 64'(mac), 64'd1);
    chk("t6.l3.valid", 64'(vc), 64'd1);
    chk("t6.l1.bubble", 64'(va), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
